// File: rtl/otf_conv_multi.sv
// otf_conv_multi
//   Multi-channel radix-2 on-the-fly converter. Each channel takes one signed
//   digit per accepted cycle, MSD first. Q and QM (= Q - 1 ulp) are kept per
//   channel, so converting to two's complement never needs a carry-propagate add.
//   When a frame of len digits completes, each channel's value is aligned to
//   2^-N and presented on o_result together with a one-cycle o_out_valid.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   i_start        begin a new frame, sample i_len, abort any frame in flight
//   i_len          digits in the frame, 1..N (0 means N)
//   i_digit_valid  i_digit carries one digit for every channel
//   i_digit        channel c at [2c+1:2c]: 01=+1, 11=-1, 00=0, 10=illegal
//   o_busy         frame in progress
//   o_out_valid    one-cycle pulse, o_result is new
//   o_result       channel c at [W(c+1)-1:Wc], two's complement of value*2^N
//   o_err          per channel, sticky until the next start: illegal code seen
//
// State table
//   state  | meaning
//   S_IDLE | waiting for i_start, digits ignored
//   S_RUN  | accepting digits until count reaches the frame length
module otf_conv_multi #(
  parameter  int N  = 8,
  parameter  int CH = 2,
  localparam int W  = N + 1,
  localparam int LW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [LW-1:0]   i_len,
  input  logic            i_digit_valid,
  input  logic [2*CH-1:0] i_digit,
  output logic            o_busy,
  output logic            o_out_valid,
  output logic [W*CH-1:0] o_result,
  output logic [CH-1:0]   o_err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [LW-1:0] N_L = LW'(N);

  state_t            r_state;
  logic [W-1:0]      r_q  [CH];
  logic [W-1:0]      r_qm [CH];
  logic [LW-1:0]     r_count;
  logic [LW-1:0]     r_len;
  logic              r_busy;
  logic              r_out_valid;
  logic [W*CH-1:0]   r_result;
  logic [CH-1:0]     r_err;

  logic [LW-1:0]     w_start_len;
  logic [LW-1:0]     w_len_eff;
  logic              w_accept;
  logic [LW-1:0]     w_count_next;
  logic              w_done;
  logic [LW-1:0]     w_shamt;
  logic [W-1:0]      w_q_base  [CH];
  logic [W-1:0]      w_qm_base [CH];
  logic [W-1:0]      w_q_next  [CH];
  logic [W-1:0]      w_qm_next [CH];
  logic [CH-1:0]     w_illegal;
  logic [1:0]        w_dig;

  always_comb begin
    w_start_len  = (i_len == '0) ? N_L : i_len;
    w_len_eff    = i_start ? w_start_len : r_len;
    w_accept     = i_digit_valid && (i_start || (r_state == S_RUN));
    // A start clears the frame first; a digit in the same cycle lands on top.
    w_count_next = (i_start ? '0 : r_count) + LW'(w_accept);
    w_done       = w_accept && (w_count_next == w_len_eff);
    w_shamt      = N_L - w_len_eff;
    w_illegal    = '0;
    w_dig        = 2'b00;
    for (int c = 0; c < CH; c++) begin
      w_q_base[c]  = i_start ? '0 : r_q[c];
      w_qm_base[c] = i_start ? '1 : r_qm[c];
      w_q_next[c]  = w_q_base[c];
      w_qm_next[c] = w_qm_base[c];
      if (w_accept) begin
        w_dig = i_digit[2*c +: 2];
        case (w_dig)
          2'b01: begin
            w_q_next[c]  = {w_q_base[c][W-2:0], 1'b1};
            w_qm_next[c] = {w_q_base[c][W-2:0], 1'b0};
          end
          2'b11: begin
            w_q_next[c]  = {w_qm_base[c][W-2:0], 1'b1};
            w_qm_next[c] = {w_qm_base[c][W-2:0], 1'b0};
          end
          default: begin
            // 00 and the illegal 10 both behave as a zero digit.
            w_q_next[c]  = {w_q_base[c][W-2:0], 1'b0};
            w_qm_next[c] = {w_qm_base[c][W-2:0], 1'b1};
          end
        endcase
        w_illegal[c] = (w_dig == 2'b10);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      for (int c = 0; c < CH; c++) begin
        r_q[c]  <= '0;
        r_qm[c] <= '1;
      end
      r_count     <= '0;
      r_len       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_err       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (i_start || w_accept) begin
        for (int c = 0; c < CH; c++) begin
          r_q[c]  <= w_q_next[c];
          r_qm[c] <= w_qm_next[c];
        end
        r_count <= w_count_next;
      end
      if (i_start) begin
        r_len <= w_start_len;
        r_err <= w_illegal;
      end else begin
        r_err <= r_err | w_illegal;
      end
      if (w_done) begin
        for (int c = 0; c < CH; c++) begin
          r_result[c*W +: W] <= w_q_next[c] << w_shamt;
        end
        r_out_valid <= 1'b1;
        r_busy      <= 1'b0;
        r_state     <= S_IDLE;
      end else if (i_start) begin
        r_busy  <= 1'b1;
        r_state <= S_RUN;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_err       = r_err;

endmodule

// File: tb/tb_otf_conv_multi.sv
module tb_otf_conv_multi;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] X = 2'b10;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [3:0]  i_len;
  logic        i_digit_valid;
  logic [3:0]  i_digit;
  logic        o_busy;
  logic        o_out_valid;
  logic [17:0] o_result;
  logic [1:0]  o_err;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses = 0;
  logic [1:0] s0 [8];

  otf_conv_multi #(.N(8), .CH(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_digit_valid(i_digit_valid), .i_digit(i_digit), .o_busy(o_busy),
    .o_out_valid(o_out_valid), .o_result(o_result), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] l, input logic dv, input logic [3:0] d);
    i_start = s;
    i_len = l;
    i_digit_valid = dv;
    i_digit = d;
    @(posedge clk);
    #1;
    if (o_out_valid) pulses++;
    i_start = 1'b0;
    i_digit_valid = 1'b0;
  endtask

  initial begin
    s0 = '{P, Z, M, P, Z, Z, M, P};
    rst = 1'b0;
    i_start = 1'b0;
    i_len = 4'd0;
    i_digit_valid = 1'b0;
    i_digit = 4'd0;
    #12;
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_ov", 32'(o_out_valid), 32'd0);
    chk("reset_result", 32'(o_result), 32'd0);
    chk("reset_err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: len 8, ch0 mixed stream, ch1 all -1
    step(1, 4'd8, 0, 4'd0);
    chk("t1_busy_rise", 32'(o_busy), 32'd1);
    pulses = 0;
    for (int i = 0; i < 7; i++) step(0, 4'd8, 1, {M, s0[i]});
    chk("t1_busy_last", 32'(o_busy), 32'd1);
    chk("t1_ov_early", 32'(pulses), 32'd0);
    step(0, 4'd8, 1, {M, s0[7]});
    chk("t1_ov", 32'(o_out_valid), 32'd1);
    chk("t1_ch0", 32'(o_result[8:0]), 32'h06F);
    chk("t1_ch1", 32'(o_result[17:9]), 32'h101);
    chk("t1_err", 32'(o_err), 32'd0);
    chk("t1_busy_fall", 32'(o_busy), 32'd0);
    step(0, 4'd8, 0, 4'd0);
    chk("t1_ov_pulse", 32'(o_out_valid), 32'd0);
    chk("t1_hold", 32'(o_result), {14'd0, 9'h101, 9'h06F});

    // Test 2: len 4, result aligned to 2^-8
    step(1, 4'd4, 0, 4'd0);
    step(0, 4'd4, 1, {Z, P});
    step(0, 4'd4, 1, {Z, P});
    step(0, 4'd4, 1, {Z, M});
    chk("t2_ov_early", 32'(o_out_valid), 32'd0);
    step(0, 4'd4, 1, {Z, P});
    chk("t2_ov", 32'(o_out_valid), 32'd1);
    chk("t2_ch0", 32'(o_result[8:0]), 32'h0B0);
    chk("t2_ch1", 32'(o_result[17:9]), 32'h000);

    // Test 3: len 0 means 8, all zero digits
    step(1, 4'd0, 0, 4'd0);
    for (int i = 0; i < 7; i++) step(0, 4'd0, 1, {Z, Z});
    chk("t3_ov_early", 32'(o_out_valid), 32'd0);
    chk("t3_busy", 32'(o_busy), 32'd1);
    step(0, 4'd0, 1, {Z, Z});
    chk("t3_ov", 32'(o_out_valid), 32'd1);
    chk("t3_result", 32'(o_result), 32'd0);

    // Test 4: test-1 stream with gaps of 1..3 idle cycles
    step(1, 4'd8, 0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 4'd8, 1, {M, s0[i]});
      if (i < 7) begin
        for (int g = 0; g <= (i % 3); g++) begin
          step(0, 4'd8, 0, {M, M});
          chk("t4_busy_gap", 32'(o_busy), 32'd1);
        end
      end
    end
    chk("t4_ov", 32'(o_out_valid), 32'd1);
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_result", 32'(o_result), {14'd0, 9'h101, 9'h06F});

    // Test 5: illegal code on ch1 digit 3
    step(1, 4'd8, 0, 4'd0);
    for (int i = 0; i < 8; i++) step(0, 4'd8, 1, {(i == 2) ? X : P, Z});
    chk("t5_ov", 32'(o_out_valid), 32'd1);
    chk("t5_err", 32'(o_err), 32'b10);
    chk("t5_ch1", 32'(o_result[17:9]), 32'h0DF);
    chk("t5_ch0", 32'(o_result[8:0]), 32'h000);
    step(1, 4'd8, 0, 4'd0);
    chk("t5_err_clear", 32'(o_err), 32'd0);

    // Test 6: abort after 5 digits, restart with start+digit_valid
    pulses = 0;
    for (int i = 0; i < 5; i++) step(0, 4'd8, 1, {P, P});
    step(1, 4'd8, 1, {M, s0[0]});
    for (int i = 1; i < 8; i++) step(0, 4'd8, 1, {M, s0[i]});
    chk("t6_pulses", 32'(pulses), 32'd1);
    chk("t6_ov", 32'(o_out_valid), 32'd1);
    chk("t6_result", 32'(o_result), {14'd0, 9'h101, 9'h06F});

    // Test 7: start coinciding with the final digit wins
    step(1, 4'd8, 0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 7; i++) step(0, 4'd8, 1, {P, P});
    step(1, 4'd8, 1, {M, M});
    chk("t7_no_ov", 32'(pulses), 32'd0);
    chk("t7_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 7; i++) step(0, 4'd8, 1, {M, M});
    chk("t7_ov", 32'(o_out_valid), 32'd1);
    chk("t7_result", 32'(o_result), {14'd0, 9'h101, 9'h101});

    // Test 8: len 1 with start+digit_valid completes at once
    step(1, 4'd1, 1, {M, P});
    chk("t8_ov", 32'(o_out_valid), 32'd1);
    chk("t8_ch0", 32'(o_result[8:0]), 32'h080);
    chk("t8_ch1", 32'(o_result[17:9]), 32'h180);
    chk("t8_busy", 32'(o_busy), 32'd0);

    // Test 9: reset mid-frame
    step(1, 4'd8, 0, 4'd0);
    step(0, 4'd8, 1, {P, X});
    step(0, 4'd8, 1, {P, P});
    step(0, 4'd8, 1, {P, P});
    chk("t9_err_pre", 32'(o_err), 32'b01);
    chk("t9_busy_pre", 32'(o_busy), 32'd1);
    rst = 1'b0;
    #2;
    chk("t9_busy", 32'(o_busy), 32'd0);
    chk("t9_ov", 32'(o_out_valid), 32'd0);
    chk("t9_result", 32'(o_result), 32'd0);
    chk("t9_err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 4'd1, 1, {P, P});
      chk("t9_idle_busy", 32'(o_busy), 32'd0);
    end
    chk("t9_idle_pulses", 32'(pulses), 32'd0);
    chk("t9_idle_result", 32'(o_result), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/otf_conv_multi.md
Name: otf_conv_multi

Overview:
- Multi-channel radix-2 on-the-fly converter (OTFC) for the MSDF datapath.
- Accepts one signed digit per channel per cycle, most significant digit first.
- Maintains Q and QM (Q minus one ulp) per channel, so no carry-propagate add is needed.
- After a frame of LEN digits, emits each channel's two's-complement result with a valid pulse. Replaces the single-register, adder-based conversion used in the serial multiplier and feeds the parallel result stage.

Parameters:
- N, 8: maximum digits per frame; result width W = N+1 bits (sign plus N fraction bits).
- CH, 2: number of independent channels sharing one control path.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a new frame; samples len; aborts any frame in progress.
- len  in  $clog2(N+1)  digits in this frame, 1..N. 0 is treated as N.
- digit_valid  in  1  digit bus carries one digit for every channel this cycle.
- digit  in  2*CH  channel c uses bits [2c+1:2c]. Encoding per Bit_rep.vh: 01 = +1, 11 = -1, 00 = 0, 10 = illegal.
- busy  out  1  frame in progress.
- out_valid  out  1  one-cycle pulse; result is new.
- result  out  W*CH  channel c uses bits [W(c+1)-1:Wc]. Two's complement of value*2^N.
- err  out  CH  sticky per channel: an illegal code was accepted this frame.

Behaviour:
- Reset (async, rst=0): state IDLE; all Q=0 and QM=all-ones; count=0; busy=0; out_valid=0; result=0; err=0.
- States:
  - IDLE: wait for start.
  - RUN: accept digits.
  - No separate done state; the completion cycle returns directly to IDLE.
- start (any state):
  - Q←0, QM←all-ones, count←0, err←0, len_r←(len==0 ? N : len), state←RUN.
  - If digit_valid is also high in that cycle, that digit is applied as digit 1 on top of the cleared registers (count becomes 1).
  - start during RUN discards the partial frame. No out_valid is produced for the aborted frame.
- Digit acceptance: a digit is accepted when state==RUN or start, and digit_valid=1. digit_valid in IDLE without start is ignored.
- Per channel, on each accepted digit q (W-bit registers, shift left, keep low W bits):
  - q=+1: Q←{Q,1}, QM←{Q,0}
  - q=0: Q←{Q,0}, QM←{QM,1}
  - q=-1: Q←{QM,1}, QM←{QM,0}
  - illegal 10: handled as q=0 and sets err[c].
- Invariants: Q_int = sum q_j·2^(k-j) after k digits, and QM = Q-1 always.
- count increments on each accepted digit.
- Completion: when the accepted digit makes count==len_r:
  - Next edge: result[c]←Q_next << (N-len_r), so alignment is always at 2^-N; out_valid←1; state←IDLE; busy←0.
  - Latency: out_valid is high the cycle after the final digit is sampled.
  - result holds until the next completion. err holds until the next start.
- busy: 1 in RUN, including the cycle the final digit is presented. It is registered: it rises the cycle after start and falls with out_valid.
- Simultaneous events:
  - start in the same cycle as a final digit: start wins, the old frame is aborted, and no out_valid is produced.
  - len=1 with start+digit_valid: completes immediately; out_valid appears on the next cycle.
- Range: values lie in (-1,1), so W bits never overflow. There is no saturation.
- Reset mid-frame: immediately returns to the reset values; the partial frame is lost.

Test Plan:
- N=8, CH=2, len=8. Ch0 digits +1,0,-1,+1,0,0,-1,+1; ch1 all -1. Required: one out_valid pulse 1 cycle after the 8th digit; ch0 result=9'h06F (111); ch1=9'h101 (-255); err=00.
- len=4, ch0 digits +1,+1,-1,+1 → ch0 result=9'h0B0 (11<<4). len=0 with 8 zero digits → result 0, out_valid after 8 digits.
- Gapped digit_valid: same stream as test 1 with 1-3 idle cycles between digits → identical results. Required: busy stays 1 throughout and out_valid timing is tied to the 8th accepted digit.
- Ch1 sends code 10 at digit 3, other digits +1 → err=2'b10; that digit counts as 0. Next start clears err to 0.
- Abort: start again after 5 digits, then feed the 8-digit stream of test 1 → exactly one out_valid pulse, with the test-1 results. start+digit_valid on the same cycle counts that digit as digit 1.
- Assert rst=0 after 3 digits → busy, out_valid, result and err go to 0 immediately. After release, digit_valid without start produces no activity.
